locker_ctrl: RTL and testbench
==============================

// Module: locker_ctrl
// PURPOSE
//  Sequencing controller for the combination locker: collects keypad digits, compares them to a stored code,
//  and drives the lock latch set/reset strobes (set_o/rst_o feed the enabled RS latch).
//  Counts failed attempts, enforces a timed lockout with alarm, and allows re-programming the code while open.
// PARAMETERS
//  CODE_LEN      4         digits per code (2..8)
//  DIGIT_W       4         bits per digit
//  DEFAULT_CODE  16'h1234  code loaded at reset, CODE_LEN*DIGIT_W bits, digit 0 in MSBs
//  MAX_FAIL      3         consecutive wrong codes before lockout (1..15)
//  LOCKOUT_CYC   1024      lockout duration in clk cycles
//  TIMEOUT_CYC   256       idle cycles mid-entry before entry is discarded
// PORTS
//  clk         in   1                  rising-edge clock
//  rst_n       in   1                  async active-low reset
//  digit_vld   in   1                  one-cycle strobe; digit accepted this cycle
//  digit       in   DIGIT_W            keypad value, sampled when digit_vld=1
//  clear       in   1                  abandon current entry
//  lock_cmd    in   1                  relock request (UNLOCKED only)
//  prog_cmd    in   1                  enter code-programming mode (UNLOCKED only)
//  set_o       out  1                  one-cycle S strobe to lock latch (open)
//  rst_o       out  1                  one-cycle R strobe to lock latch (close)
//  unlocked    out  1                  level, 1 in UNLOCKED/PROGRAM
//  alarm       out  1                  level, 1 in LOCKOUT
//  entry_cnt   out  $clog2(CODE_LEN+1) digits captured so far
//  fail_cnt    out  4                  consecutive failures
// BEHAVIOUR
//  Reset (async, rst_n=0): state=LOCKED, code=DEFAULT_CODE, entry buffer/entry_cnt/fail_cnt/timers=0;
//   set_o=0, rst_o=0, unlocked=0, alarm=0. Reset mid-entry/mid-lockout discards everything; reset does not strobe rst_o.
//  States: LOCKED, ENTRY, CHECK, UNLOCKED, PROGRAM, LOCKOUT. All outputs registered.
//  LOCKED: digit_vld -> shift digit in, entry_cnt=1, go ENTRY.
//  ENTRY: each digit_vld shifts in, entry_cnt++; when entry_cnt reaches CODE_LEN -> CHECK next cycle.
//   clear, or TIMEOUT_CYC cycles with no digit_vld -> flush buffer, entry_cnt=0, LOCKED; timeout does not count as a failure.
//   clear and digit_vld in the same cycle: clear wins, digit dropped.
//  CHECK (1 cycle): match -> fail_cnt=0, set_o=1 for 1 cycle, UNLOCKED.
//   mismatch -> fail_cnt++; if new fail_cnt==MAX_FAIL -> LOCKOUT, else LOCKED. Buffer flushed either way.
//   digit_vld in CHECK is ignored.
//  Latency: last digit strobe at cycle N -> set_o high at N+2, unlocked high at N+2.
//  UNLOCKED: lock_cmd -> rst_o=1 for 1 cycle, LOCKED. prog_cmd -> PROGRAM, entry_cnt=0.
//   lock_cmd has priority over prog_cmd. Digits are ignored.
//  PROGRAM: collect CODE_LEN digits as in ENTRY, with the same clear/timeout rules.
//   On the CODE_LEN-th digit, code <= buffer, then UNLOCKED.
//   clear/timeout -> UNLOCKED, code unchanged. lock_cmd -> rst_o pulse, LOCKED, code unchanged.
//  LOCKOUT: alarm=1; all inputs ignored; down-counter from LOCKOUT_CYC-1.
//   At 0 -> fail_cnt=0, alarm=0, LOCKED. Exactly LOCKOUT_CYC cycles with alarm=1.
//  fail_cnt saturates at MAX_FAIL. Entry buffer is a CODE_LEN-deep shift register; comparison is full-width equality.
// STRUCTURE
//  locker_pkg: state encoding localparams (S_LOCKED..S_LOCKOUT), CNT_W function/localparam, digit width.
//  One sub-module: locker_timer (loadable down-counter with zero flag), shared by the entry timeout and the lockout.
//   Max load = max(LOCKOUT_CYC, TIMEOUT_CYC).
//  Code register, entry shift register and FSM stay in locker_ctrl.
// TESTING (bench: LOCKOUT_CYC=20, TIMEOUT_CYC=8, DEFAULT_CODE=16'h1234)
//  Correct entry: digits 1,2,3,4 -> set_o one-cycle pulse 2 cycles after '4'; unlocked=1; fail_cnt=0.
//  Relock: lock_cmd in UNLOCKED -> rst_o single pulse; unlocked=0; a further lock_cmd produces no pulse.
//  Lockout: 3 entries of 1,2,3,5 -> fail_cnt 1,2,3; alarm=1 for exactly 20 cycles; digits ignored meanwhile;
//   afterwards 1,2,3,4 unlocks.
//  Timeout/clear: digits 1,2 then 8 idle cycles -> entry_cnt=0, fail_cnt unchanged.
//   clear+digit_vld in same cycle -> entry_cnt=0.
//  Programming: unlock, prog_cmd, digits 9,8,7,6, lock_cmd -> 1,2,3,4 fails; 9,8,7,6 unlocks.
//   Aborted program (clear after 2 digits) keeps the old code.
//  Async reset: assert rst_n=0 during LOCKOUT and after programming -> alarm=0 immediately; code back to 1234;
//   no rst_o pulse.

Source files
------------

// File: rtl/locker_pkg.sv
// Shared definitions for the combination-locker controller: FSM states,
// default digit width and width helpers.
package locker_pkg;

    localparam int unsigned DIGIT_W_DEF = 4;

    typedef enum logic [2:0] {
        S_LOCKED,
        S_ENTRY,
        S_CHECK,
        S_UNLOCKED,
        S_PROGRAM,
        S_LOCKOUT
    } state_t;

    // Bits needed to hold the values 0..n inclusive.
    function automatic int unsigned cnt_w(input int unsigned n);
        return (n < 1) ? 1 : $clog2(n + 1);
    endfunction

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/locker_timer.sv
// Loadable down-counter with zero flag. It is shared by the entry timeout
// and the lockout interval, which are never active at the same time.
module locker_timer
    import locker_pkg::*;
#(
    parameter int unsigned MAX_LOAD = 1024,
    localparam int unsigned TW      = cnt_w(MAX_LOAD)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic [TW-1:0] load_val,
    output logic          zero
);

    logic [TW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - TW'(1);
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/locker_ctrl.sv
// Combination-locker sequencer: digit capture, code compare, latch strobes,
// failure counting with timed lockout, and code re-programming while open.
module locker_ctrl
    import locker_pkg::*;
#(
    parameter int unsigned                  CODE_LEN     = 4,
    parameter int unsigned                  DIGIT_W      = DIGIT_W_DEF,
    parameter logic [CODE_LEN*DIGIT_W-1:0]  DEFAULT_CODE = 16'h1234,
    parameter int unsigned                  MAX_FAIL     = 3,
    parameter int unsigned                  LOCKOUT_CYC  = 1024,
    parameter int unsigned                  TIMEOUT_CYC  = 256
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         digit_vld,
    input  logic [DIGIT_W-1:0]           digit,
    input  logic                         clear,
    input  logic                         lock_cmd,
    input  logic                         prog_cmd,
    output logic                         set_o,
    output logic                         rst_o,
    output logic                         unlocked,
    output logic                         alarm,
    output logic [cnt_w(CODE_LEN)-1:0]   entry_cnt,
    output logic [3:0]                   fail_cnt
);

    localparam int unsigned CODE_W  = CODE_LEN * DIGIT_W;
    localparam int unsigned CNT_W   = cnt_w(CODE_LEN);
    localparam int unsigned TMR_MAX = max_u(LOCKOUT_CYC, TIMEOUT_CYC);
    localparam int unsigned TW      = cnt_w(TMR_MAX);

    localparam logic [TW-1:0]    TMR_TO    = TW'(TIMEOUT_CYC - 1);
    localparam logic [TW-1:0]    TMR_LOCK  = TW'(LOCKOUT_CYC - 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CODE_LEN - 1);
    localparam logic [3:0]       FAIL_MAX4 = 4'(MAX_FAIL);

    state_t              state;
    logic [CODE_W-1:0]   code;
    logic [CODE_W-1:0]   entry_buf;
    logic [CODE_W-1:0]   shifted;
    logic                match;
    logic                digit_take;
    logic [3:0]          fail_next;
    logic                tmr_load;
    logic [TW-1:0]       tmr_val;
    logic                tmr_zero;

    assign shifted    = {entry_buf[CODE_W-DIGIT_W-1:0], digit};
    assign match      = (entry_buf == code);
    assign digit_take = digit_vld && !clear;
    assign fail_next  = (fail_cnt < FAIL_MAX4) ? fail_cnt + 4'd1 : fail_cnt;

    // Timer reload mirrors the FSM transitions that start a timed interval.
    always_comb begin
        tmr_load = 1'b0;
        tmr_val  = TMR_TO;
        case (state)
            S_LOCKED,
            S_ENTRY:    tmr_load = digit_take;
            S_PROGRAM:  tmr_load = digit_take && !lock_cmd;
            S_UNLOCKED: tmr_load = prog_cmd && !lock_cmd;
            S_CHECK: begin
                if (!match && fail_next == FAIL_MAX4) begin
                    tmr_load = 1'b1;
                    tmr_val  = TMR_LOCK;
                end
            end
            default: tmr_load = 1'b0;
        endcase
    end

    locker_timer #(
        .MAX_LOAD (TMR_MAX)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_LOCKED;
            code      <= DEFAULT_CODE;
            entry_buf <= '0;
            entry_cnt <= '0;
            fail_cnt  <= '0;
            set_o     <= 1'b0;
            rst_o     <= 1'b0;
            unlocked  <= 1'b0;
            alarm     <= 1'b0;
        end else begin
            set_o <= 1'b0;
            rst_o <= 1'b0;
            case (state)
                S_LOCKED: begin
                    if (digit_take) begin
                        entry_buf <= shifted;
                        entry_cnt <= CNT_W'(1);
                        state     <= S_ENTRY;
                    end
                end
                S_ENTRY: begin
                    if (clear) begin
                        entry_buf <= '0;
                        entry_cnt <= '0;
                        state     <= S_LOCKED;
                    end else if (digit_vld) begin
                        entry_buf <= shifted;
                        entry_cnt <= entry_cnt + CNT_W'(1);
                        if (entry_cnt == CNT_LAST) state <= S_CHECK;
                    end else if (tmr_zero) begin
                        entry_buf <= '0;
                        entry_cnt <= '0;
                        state     <= S_LOCKED;
                    end
                end
                S_CHECK: begin
                    entry_buf <= '0;
                    entry_cnt <= '0;
                    if (match) begin
                        fail_cnt <= '0;
                        set_o    <= 1'b1;
                        unlocked <= 1'b1;
                        state    <= S_UNLOCKED;
                    end else begin
                        fail_cnt <= fail_next;
                        if (fail_next == FAIL_MAX4) begin
                            alarm <= 1'b1;
                            state <= S_LOCKOUT;
                        end else begin
                            state <= S_LOCKED;
                        end
                    end
                end
                S_UNLOCKED: begin
                    if (lock_cmd) begin
                        rst_o    <= 1'b1;
                        unlocked <= 1'b0;
                        state    <= S_LOCKED;
                    end else if (prog_cmd) begin
                        entry_buf <= '0;
                        entry_cnt <= '0;
                        state     <= S_PROGRAM;
                    end
                end
                S_PROGRAM: begin
                    if (lock_cmd) begin
                        rst_o     <= 1'b1;
                        unlocked  <= 1'b0;
                        entry_buf <= '0;
                        entry_cnt <= '0;
                        state     <= S_LOCKED;
                    end else if (clear) begin
                        entry_buf <= '0;
                        entry_cnt <= '0;
                        state     <= S_UNLOCKED;
                    end else if (digit_vld) begin
                        if (entry_cnt == CNT_LAST) begin
                            code      <= shifted;
                            entry_buf <= '0;
                            entry_cnt <= '0;
                            state     <= S_UNLOCKED;
                        end else begin
                            entry_buf <= shifted;
                            entry_cnt <= entry_cnt + CNT_W'(1);
                        end
                    end else if (tmr_zero) begin
                        entry_buf <= '0;
                        entry_cnt <= '0;
                        state     <= S_UNLOCKED;
                    end
                end
                S_LOCKOUT: begin
                    if (tmr_zero) begin
                        fail_cnt <= '0;
                        alarm    <= 1'b0;
                        state    <= S_LOCKED;
                    end
                end
                default: state <= S_LOCKED;
            endcase
        end
    end

endmodule

// File: tb/tb_locker_ctrl.sv
// Bench for locker_ctrl: directed stimulus, strobe scoreboard checked by an
// independent monitor, plus direct checks of the level outputs.
module tb_locker_ctrl;

    logic       clk       = 1'b0;
    logic       rst_n     = 1'b0;
    logic       digit_vld = 1'b0;
    logic [3:0] digit     = '0;
    logic       clear     = 1'b0;
    logic       lock_cmd  = 1'b0;
    logic       prog_cmd  = 1'b0;
    logic       set_o;
    logic       rst_o;
    logic       unlocked;
    logic       alarm;
    logic [2:0] entry_cnt;
    logic [3:0] fail_cnt;

    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;

    typedef struct {
        bit          is_set;
        int unsigned cyc;
    } strobe_t;

    strobe_t exp_q[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    locker_ctrl #(
        .CODE_LEN     (4),
        .DIGIT_W      (4),
        .DEFAULT_CODE (16'h1234),
        .MAX_FAIL     (3),
        .LOCKOUT_CYC  (20),
        .TIMEOUT_CYC  (8)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .digit_vld (digit_vld),
        .digit     (digit),
        .clear     (clear),
        .lock_cmd  (lock_cmd),
        .prog_cmd  (prog_cmd),
        .set_o     (set_o),
        .rst_o     (rst_o),
        .unlocked  (unlocked),
        .alarm     (alarm),
        .entry_cnt (entry_cnt),
        .fail_cnt  (fail_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Monitor: every strobe the DUT emits must match the head of the queue.
    initial begin
        strobe_t e;
        forever begin
            @(negedge clk);
            if (set_o === 1'b1 || rst_o === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_strobe: got set_o=%0b rst_o=%0b at cycle %0d, expected none",
                             set_o, rst_o, cyc);
                end else begin
                    e = exp_q.pop_front();
                    chk("strobe_set_o", set_o, e.is_set);
                    chk("strobe_rst_o", rst_o, !e.is_set);
                    chk("strobe_cycle", cyc, e.cyc);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [3:0] d, input logic c,
                         input logic l, input logic p);
        digit_vld = v;
        digit     = d;
        clear     = c;
        lock_cmd  = l;
        prog_cmd  = p;
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic feed(input logic [15:0] code, input bit exp_set);
        logic [3:0] d;
        for (int i = 0; i < 4; i++) begin
            d = code[15-4*i -: 4];
            if (i == 3 && exp_set) exp_q.push_back('{is_set: 1'b1, cyc: cyc + 2});
            drive(1'b1, d, 1'b0, 1'b0, 1'b0);
        end
    endtask

    task automatic enter(input logic [15:0] code, input bit exp_set);
        feed(code, exp_set);
        idle(2);
    endtask

    task automatic do_lock(input bit exp_pulse);
        if (exp_pulse) exp_q.push_back('{is_set: 1'b0, cyc: cyc + 1});
        drive(1'b0, 4'h0, 1'b0, 1'b1, 1'b0);
        idle(1);
    endtask

    initial begin
        int n_alarm;
        bit seen;

        repeat (3) @(negedge clk);
        chk("rst_unlocked", unlocked, 0);
        chk("rst_alarm", alarm, 0);
        chk("rst_set_o", set_o, 0);
        chk("rst_rst_o", rst_o, 0);
        chk("rst_entry_cnt", entry_cnt, 0);
        chk("rst_fail_cnt", fail_cnt, 0);
        rst_n = 1'b1;
        idle(1);

        // Correct code and relock
        enter(16'h1234, 1);
        chk("open_unlocked", unlocked, 1);
        chk("open_fail_cnt", fail_cnt, 0);
        chk("open_entry_cnt", entry_cnt, 0);
        do_lock(1);
        chk("relock_unlocked", unlocked, 0);
        do_lock(0);
        idle(2);

        // Three wrong codes -> lockout
        enter(16'h1235, 0);
        chk("fail1", fail_cnt, 1);
        enter(16'h1235, 0);
        chk("fail2", fail_cnt, 2);
        chk("fail2_alarm", alarm, 0);
        feed(16'h1235, 0);
        n_alarm = 0;
        seen    = 0;
        for (int i = 0; i < 60; i++) begin
            drive(1'b1, 4'(i), 1'b0, (i % 4) == 1, (i % 4) == 3);
            if (alarm) begin
                if (!seen) chk("lockout_fail_cnt", fail_cnt, 3);
                seen = 1;
                n_alarm++;
            end else if (seen) begin
                break;
            end
        end
        chk("alarm_cycles", n_alarm, 20);
        chk("post_lockout_entry_cnt", entry_cnt, 0);
        chk("post_lockout_fail_cnt", fail_cnt, 0);
        chk("post_lockout_unlocked", unlocked, 0);
        enter(16'h1234, 1);
        chk("post_lockout_open", unlocked, 1);
        do_lock(1);

        // Entry timeout boundary and clear priority
        enter(16'h5555, 0);
        chk("pre_timeout_fail", fail_cnt, 1);
        drive(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
        chk("two_digits_cnt", entry_cnt, 2);
        idle(7);
        chk("idle7_entry_cnt", entry_cnt, 2);
        idle(1);
        chk("idle8_entry_cnt", entry_cnt, 0);
        chk("timeout_fail_cnt", fail_cnt, 1);
        drive(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'h2, 1'b1, 1'b0, 1'b0);
        chk("clear_digit_cnt", entry_cnt, 0);
        enter(16'h1234, 1);
        chk("after_clear_open", unlocked, 1);
        chk("after_clear_fail", fail_cnt, 0);

        // Programming a new code
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        feed(16'h9876, 0);
        idle(1);
        chk("prog_unlocked", unlocked, 1);
        chk("prog_entry_cnt", entry_cnt, 0);
        do_lock(1);
        enter(16'h1234, 0);
        chk("old_code_rejected", fail_cnt, 1);
        chk("old_code_locked", unlocked, 0);
        enter(16'h9876, 1);
        chk("new_code_open", unlocked, 1);
        chk("new_code_fail", fail_cnt, 0);

        // Aborted programming keeps the current code
        drive(1'b0, 4'h0, 1'b0, 1'b0, 1'b1);
        drive(1'b1, 4'h1, 1'b0, 1'b0, 1'b0);
        drive(1'b1, 4'h2, 1'b0, 1'b0, 1'b0);
        drive(1'b0, 4'h0, 1'b1, 1'b0, 1'b0);
        chk("abort_unlocked", unlocked, 1);
        chk("abort_entry_cnt", entry_cnt, 0);
        do_lock(1);
        enter(16'h1234, 0);
        chk("abort_1234_fails", fail_cnt, 1);
        enter(16'h9876, 1);
        chk("abort_9876_open", unlocked, 1);

        // Async reset while open restores the default code
        #2 rst_n = 1'b0;
        #1 chk("areset_unlocked", unlocked, 0);
        chk("areset_fail_cnt", fail_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        enter(16'h1234, 1);
        chk("areset_default_code", unlocked, 1);
        do_lock(1);

        // Async reset during lockout
        enter(16'h1235, 0);
        enter(16'h1235, 0);
        feed(16'h1235, 0);
        idle(3);
        chk("lockout2_alarm", alarm, 1);
        #2 rst_n = 1'b0;
        #1 chk("areset_alarm", alarm, 0);
        chk("areset_lockout_fail", fail_cnt, 0);
        chk("areset_lockout_entry", entry_cnt, 0);
        @(negedge clk) rst_n = 1'b1;
        enter(16'h1234, 1);
        chk("final_open", unlocked, 1);
        idle(3);

        chk("pending_strobes", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
        $fatal(1);
    end

endmodule
